// File: rtl/thumb_imm_decoder.sv
// Thumb decode-stage immediate generator: 16-bit forms, BL pairs, prefix FSM.
// Optional Thumb-2 modified immediates: define IMM_GEN_T2_MODIFIED_IMM_EN.
module thumb_imm_decoder #(
    parameter int WORD_W      = 32,
    parameter bit ZERO_UNUSED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       instr_i,
    input  logic              instr_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] imm_o,
    output logic              imm_valid_o,
    output logic              wide_o,
    output logic              unsupported_o
);

    typedef enum logic {IDLE, WAIT_HW2} state_t;

    state_t            state, state_nx;
    logic [15:0]       prefix, prefix_nx;
    logic [WORD_W-1:0] imm_nx;
    logic              valid_nx, wide_nx, unsup_nx;

    logic [WORD_W-1:0] imm16;
    logic              has16;
    logic              is_prefix;

    logic [WORD_W-1:0] bl_imm;
    logic              is_bl;
    logic              bl_s, bl_i1, bl_i2;
    logic [24:0]       bl_raw;

    assign is_prefix = (instr_i[15:11] == 5'b11101) ||
                       (instr_i[15:11] == 5'b11110) ||
                       (instr_i[15:11] == 5'b11111);

    // 16-bit immediate extraction and scaling
    always_comb begin
        imm16 = '0;
        has16 = 1'b1;
        if (instr_i[15:11] == 5'b00011) begin
            imm16 = instr_i[10] ? WORD_W'(instr_i[8:6]) : '0;
        end else if (instr_i[15:13] == 3'b000) begin
            imm16 = WORD_W'(instr_i[10:6]);
        end else if (instr_i[15:13] == 3'b001) begin
            imm16 = WORD_W'(instr_i[7:0]);
        end else if (instr_i[15:11] == 5'b01001) begin
            imm16 = WORD_W'({instr_i[7:0], 2'b00});
        end else if (instr_i[15:12] == 4'b0110) begin
            imm16 = WORD_W'({instr_i[10:6], 2'b00});
        end else if (instr_i[15:12] == 4'b0111) begin
            imm16 = WORD_W'(instr_i[10:6]);
        end else if (instr_i[15:12] == 4'b1000) begin
            imm16 = WORD_W'({instr_i[10:6], 1'b0});
        end else if (instr_i[15:12] == 4'b1001 ||
                     instr_i[15:12] == 4'b1010) begin
            imm16 = WORD_W'({instr_i[7:0], 2'b00});
        end else if (instr_i[15:8] == 8'b1011_0000) begin
            imm16 = WORD_W'({instr_i[6:0], 2'b00});
        end else if (instr_i[15:12] == 4'b1101 &&
                     instr_i[11:9] != 3'b111) begin
            imm16 = WORD_W'($signed({instr_i[7:0], 1'b0}));
        end else if (instr_i[15:11] == 5'b11100) begin
            imm16 = WORD_W'($signed({instr_i[10:0], 1'b0}));
        end else begin
            has16 = 1'b0;
        end
    end

    // BL offset assembly from stored prefix and current suffix
    always_comb begin
        is_bl  = (prefix[15:11] == 5'b11110) &&
                 (instr_i[15:14] == 2'b11) && instr_i[12];
        bl_s   = prefix[10];
        bl_i1  = ~(instr_i[13] ^ bl_s);
        bl_i2  = ~(instr_i[11] ^ bl_s);
        bl_raw = {bl_s, bl_i1, bl_i2, prefix[9:0], instr_i[10:0], 1'b0};
        bl_imm = WORD_W'($signed(bl_raw));
    end

`ifdef IMM_GEN_T2_MODIFIED_IMM_EN
    logic [11:0] imm12;
    logic [31:0] t2_base;
    logic [4:0]  t2_rot;
    logic [31:0] t2_imm;
    logic        is_t2;

    // ThumbExpandImm of the 12-bit modified immediate
    always_comb begin
        is_t2   = (prefix[15:11] == 5'b11110) && !prefix[9] && !instr_i[15];
        imm12   = {prefix[10], instr_i[14:12], instr_i[7:0]};
        t2_base = {24'd0, 1'b1, imm12[6:0]};
        t2_rot  = imm12[11:7];
        t2_imm  = (t2_base >> t2_rot) | (t2_base << (6'd32 - {1'b0, t2_rot}));
        if (imm12[11:10] == 2'b00) begin
            case (imm12[9:8])
                2'b00:   t2_imm = {24'd0, imm12[7:0]};
                2'b01:   t2_imm = {8'd0, imm12[7:0], 8'd0, imm12[7:0]};
                2'b10:   t2_imm = {imm12[7:0], 8'd0, imm12[7:0], 8'd0};
                default: t2_imm = {4{imm12[7:0]}};
            endcase
        end
    end
`endif

    // Prefix FSM next state and next registered outputs
    always_comb begin
        state_nx  = state;
        prefix_nx = prefix;
        imm_nx    = imm_o;
        valid_nx  = 1'b0;
        wide_nx   = 1'b0;
        unsup_nx  = 1'b0;
        if (instr_valid_i) begin
            case (state)
                IDLE: begin
                    if (is_prefix) begin
                        prefix_nx = instr_i;
                        state_nx  = WAIT_HW2;
                    end else begin
                        valid_nx = 1'b1;
                        if (has16) begin
                            imm_nx = imm16;
                        end else if (ZERO_UNUSED) begin
                            imm_nx = '0;
                        end
                    end
                end
                default: begin
                    valid_nx  = 1'b1;
                    wide_nx   = 1'b1;
                    state_nx  = IDLE;
                    prefix_nx = '0;
                    if (is_bl) begin
                        imm_nx = bl_imm;
`ifdef IMM_GEN_T2_MODIFIED_IMM_EN
                    end else if (is_t2) begin
                        imm_nx = WORD_W'(t2_imm);
`endif
                    end else begin
                        imm_nx   = '0;
                        unsup_nx = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers: reset > flush > stall > accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            prefix        <= '0;
            imm_o         <= '0;
            imm_valid_o   <= 1'b0;
            wide_o        <= 1'b0;
            unsupported_o <= 1'b0;
        end else if (flush_i) begin
            state         <= IDLE;
            prefix        <= '0;
            imm_valid_o   <= 1'b0;
            wide_o        <= 1'b0;
            unsupported_o <= 1'b0;
        end else if (!stall_i) begin
            state         <= state_nx;
            prefix        <= prefix_nx;
            imm_o         <= imm_nx;
            imm_valid_o   <= valid_nx;
            wide_o        <= wide_nx;
            unsupported_o <= unsup_nx;
        end
    end

endmodule

// File: tb/tb_thumb_imm_decoder.sv
// Directed self-checking bench for thumb_imm_decoder.
module tb_thumb_imm_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] imm;
    logic        imm_valid, wide, unsup;

    int tests = 0;
    int fails = 0;

    thumb_imm_decoder #(.WORD_W(32), .ZERO_UNUSED(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr),
        .instr_valid_i(instr_valid), .stall_i(stall), .flush_i(flush),
        .imm_o(imm), .imm_valid_o(imm_valid), .wide_o(wide),
        .unsupported_o(unsup)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [15:0] hw);
        instr_valid = v;
        instr = hw;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 16'h0148);
        cyc(1'b1, 16'h0148);
        tests++;
        if ({imm, imm_valid, wide, unsup} !== 35'd0) begin
            fails++;
            $display("FAIL reset got=%h/%b%b%b want=0/000", imm, imm_valid, wide, unsup);
        end
        rst = 1'b0;
    endtask

    task automatic test_16bit();
        logic [15:0] hw [9] = '{16'h0148, 16'h4801, 16'hD0FE, 16'h2A7F,
                                16'hE7FE, 16'h6848, 16'hB082, 16'h1D88, 16'h8888};
        logic [31:0] ex [9] = '{32'h5, 32'h4, 32'hFFFFFFFC, 32'h7F,
                                32'hFFFFFFFC, 32'h4, 32'h8, 32'h6, 32'h4};
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, hw[i]);
            tests++;
            if (imm !== ex[i] || imm_valid !== 1'b1 || wide !== 1'b0) begin
                fails++;
                $display("FAIL dec16 hw=%h got=%h v%b w%b want=%h v1 w0",
                         hw[i], imm, imm_valid, wide, ex[i]);
            end
        end
        cyc(1'b1, 16'hDE00);
        tests++;
        if (imm !== 32'h0 || imm_valid !== 1'b1) begin
            fails++;
            $display("FAIL unused16 got=%h v%b want=0 v1", imm, imm_valid);
        end
        cyc(1'b0, 16'h0148);
        tests++;
        if (imm_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_valid got=%b want=0", imm_valid);
        end
    endtask

    task automatic test_bl();
        cyc(1'b1, 16'hF7FF);
        tests++;
        if (imm_valid !== 1'b0) begin
            fails++;
            $display("FAIL bl_prefix valid got=%b want=0", imm_valid);
        end
        cyc(1'b1, 16'hFFFE);
        tests++;
        if (imm !== 32'hFFFFFFFC || imm_valid !== 1'b1 || wide !== 1'b1 || unsup !== 1'b0) begin
            fails++;
            $display("FAIL bl_neg got=%h v%b w%b u%b want=fffffffc v1 w1 u0",
                     imm, imm_valid, wide, unsup);
        end
        cyc(1'b1, 16'hF000);
        cyc(1'b1, 16'hF804);
        tests++;
        if (imm !== 32'h8 || imm_valid !== 1'b1 || wide !== 1'b1) begin
            fails++;
            $display("FAIL bl_pos got=%h v%b w%b want=8 v1 w1", imm, imm_valid, wide);
        end
        cyc(1'b1, 16'hE800);
        cyc(1'b1, 16'h0000);
        tests++;
        if (imm !== 32'h0 || unsup !== 1'b1 || wide !== 1'b1 || imm_valid !== 1'b1) begin
            fails++;
            $display("FAIL unsup32 got=%h u%b w%b v%b want=0 u1 w1 v1",
                     imm, unsup, wide, imm_valid);
        end
    endtask

    task automatic test_flush();
        cyc(1'b1, 16'hF000);
        flush = 1'b1;
        cyc(1'b1, 16'h0148);
        flush = 1'b0;
        tests++;
        if (imm_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid got=%b want=0", imm_valid);
        end
        cyc(1'b1, 16'h0148);
        tests++;
        if (imm !== 32'h5 || wide !== 1'b0 || imm_valid !== 1'b1) begin
            fails++;
            $display("FAIL after_flush got=%h w%b v%b want=5 w0 v1", imm, wide, imm_valid);
        end
    endtask

    task automatic test_stall();
        cyc(1'b1, 16'hF000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'hF804);
            tests++;
            if (imm !== 32'h5 || imm_valid !== 1'b0 || wide !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold got=%h v%b w%b want=5 v0 w0", imm, imm_valid, wide);
            end
        end
        stall = 1'b0;
        cyc(1'b1, 16'hF804);
        tests++;
        if (imm !== 32'h8 || imm_valid !== 1'b1 || wide !== 1'b1) begin
            fails++;
            $display("FAIL stall_release got=%h v%b w%b want=8 v1 w1", imm, imm_valid, wide);
        end
        stall = 1'b1;
        cyc(1'b1, 16'h0148);
        cyc(1'b1, 16'h0148);
        tests++;
        if (imm !== 32'h8 || imm_valid !== 1'b1 || wide !== 1'b1) begin
            fails++;
            $display("FAIL stall_valid_hold got=%h v%b w%b want=8 v1 w1", imm, imm_valid, wide);
        end
        stall = 1'b0;
        cyc(1'b0, 16'h0148);
        tests++;
        if (imm_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_then_idle got=%b want=0", imm_valid);
        end
    endtask

    task automatic test_t2();
        logic [31:0] ex_a, ex_b;
        logic        ex_u;
`ifdef IMM_GEN_T2_MODIFIED_IMM_EN
        ex_a = 32'h00AB00AB;
        ex_b = 32'h40000000;
        ex_u = 1'b0;
`else
        ex_a = 32'h0;
        ex_b = 32'h0;
        ex_u = 1'b1;
`endif
        cyc(1'b1, 16'hF04F);
        cyc(1'b1, 16'h10AB);
        tests++;
        if (imm !== ex_a || unsup !== ex_u || wide !== 1'b1) begin
            fails++;
            $display("FAIL t2_rep got=%h u%b w%b want=%h u%b w1", imm, unsup, wide, ex_a, ex_u);
        end
        cyc(1'b1, 16'hF04F);
        cyc(1'b1, 16'h4080);
        tests++;
        if (imm !== ex_b || unsup !== ex_u || wide !== 1'b1) begin
            fails++;
            $display("FAIL t2_rot got=%h u%b w%b want=%h u%b w1", imm, unsup, wide, ex_b, ex_u);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 16'h0148);
        cyc(1'b1, 16'hF000);
        rst = 1'b1;
        cyc(1'b1, 16'hF804);
        rst = 1'b0;
        tests++;
        if ({imm, imm_valid, wide, unsup} !== 35'd0) begin
            fails++;
            $display("FAIL reset_mid got=%h/%b%b%b want=0/000", imm, imm_valid, wide, unsup);
        end
        cyc(1'b1, 16'hF804);
        tests++;
        if (imm !== 32'h0 || wide !== 1'b0) begin
            fails++;
            $display("FAIL post_reset got=%h w%b want=0 w0", imm, wide);
        end
        flush = 1'b1;
        cyc(1'b0, 16'h0000);
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_16bit();
        test_bl();
        test_flush();
        test_stall();
        test_t2();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
